// File: rtl/prediction_history_queue_pkg.sv
// Shared prediction types: the history record stored per in-flight branch,
// its table index width and the default slot-tag type.
package prediction_history_queue_pkg;

    localparam int INDEX_LEN  = 8;
    localparam int TARGET_LEN = 16;
    localparam int HIST_DEPTH = 8;

    typedef struct packed {
        logic [INDEX_LEN-1:0]  index;
        logic                  taken;
        logic [TARGET_LEN-1:0] target;
    } history_entry_t;

    typedef logic [$clog2(HIST_DEPTH)-1:0] hist_tag_t;

    function automatic logic index_match(input history_entry_t entry,
                                         input logic [INDEX_LEN-1:0] idx);
        return entry.index == idx;
    endfunction

endpackage

// File: rtl/prediction_history_queue_history_cam.sv
// history_cam: DEPTH-way index compare with newest-first priority,
// where "newest" is the slot just behind the tail pointer.
module history_cam
    import prediction_history_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  history_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]           valid,
    input  logic [TAG_W-1:0]           tail,
    input  logic [INDEX_LEN-1:0]       query_index,
    output logic                       hit,
    output logic [TAG_W-1:0]           slot,
    output history_entry_t             entry
);

    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = valid[gi] && index_match(entries[gi], query_index);
        end
    endgenerate

    // Walk from the oldest position (tail) to the newest (tail-1) so the
    // last match seen, i.e. the youngest, is the one that sticks.
    always_comb begin
        logic [TAG_W-1:0] cand;
        hit   = 1'b0;
        slot  = '0;
        entry = '0;
        cand  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            cand = tail - TAG_W'(k);
            if (match[cand]) begin
                hit   = 1'b1;
                slot  = cand;
                entry = entries[cand];
            end
        end
    end

endmodule

// File: rtl/prediction_history_queue.sv
// Circular queue of in-flight branch predictions with push, in-order retire,
// mispredict flush and newest-wins index lookup. Optional macro
// PRED_HIST_BYPASS_EN lets a same-cycle accepted push take part in the query.
module prediction_history_queue
    import prediction_history_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_stalling,
    input  logic                 push_valid,
    input  history_entry_t       push_entry,
    output logic                 push_ready,
    output logic [TAG_W-1:0]     push_tag,
    input  logic [INDEX_LEN-1:0] query_index,
    output logic                 query_hit,
    output history_entry_t       query_history,
    output logic [TAG_W-1:0]     query_tag,
    input  logic                 retire_valid,
    output history_entry_t       retire_history,
    input  logic                 flush_valid,
    input  logic [TAG_W-1:0]     flush_tag,
    output logic                 full,
    output logic                 empty,
    output logic [TAG_W:0]       count
);

    history_entry_t [DEPTH-1:0] entries_reg;
    logic [DEPTH-1:0]           valid_reg, valid_next;
    logic [TAG_W-1:0]           head_reg, head_next;
    logic [TAG_W-1:0]           tail_reg, tail_next;
    logic [TAG_W:0]             count_reg, count_next;

    logic             push_fire, retire_fire, flush_fire;
    logic [TAG_W-1:0] flush_span;
    logic [DEPTH-1:0] keep;

    assign full       = count_reg[TAG_W];
    assign empty      = (count_reg == '0);
    assign count      = count_reg;
    assign push_ready = !full;
    assign push_tag   = tail_reg;

    assign flush_fire  = flush_valid && valid_reg[flush_tag];
    assign retire_fire = retire_valid && !empty;
    // Gated by reset so a held push cannot bypass into the query while in reset.
    assign push_fire   = reset && push_valid && !full && !is_stalling && !flush_fire;

    // Distance from head to the flushed slot; every slot at or before it survives.
    assign flush_span = flush_tag - head_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [TAG_W-1:0] slot_age;
            assign slot_age       = TAG_W'(gi) - head_reg;
            assign keep[gi]       = (slot_age <= flush_span);
            assign valid_next[gi] = (push_fire && tail_reg == TAG_W'(gi))
                                 || (valid_reg[gi]
                                     && !(flush_fire && !keep[gi])
                                     && !(retire_fire && head_reg == TAG_W'(gi)));
        end
    endgenerate

    always_comb begin
        head_next  = head_reg + TAG_W'(retire_fire);
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_fire) begin
            tail_next  = flush_tag + TAG_W'(1);
            count_next = {1'b0, flush_span} + (TAG_W+1)'(1) - (TAG_W+1)'(retire_fire);
        end else begin
            tail_next  = tail_reg + TAG_W'(push_fire);
            count_next = count_reg + (TAG_W+1)'(push_fire) - (TAG_W+1)'(retire_fire);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload needs no reset: it is only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            entries_reg[tail_reg] <= push_entry;
        end
    end

    assign retire_history = valid_reg[head_reg] ? entries_reg[head_reg] : '0;

    logic             cam_hit;
    logic [TAG_W-1:0] cam_slot;
    history_entry_t   cam_entry;

    history_cam #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_cam (
        .entries     (entries_reg),
        .valid       (valid_reg),
        .tail        (tail_reg),
        .query_index (query_index),
        .hit         (cam_hit),
        .slot        (cam_slot),
        .entry       (cam_entry)
    );

    always_comb begin
        query_hit     = cam_hit;
        query_tag     = cam_slot;
        query_history = cam_entry;
`ifdef PRED_HIST_BYPASS_EN
        if (push_fire && push_entry.index == query_index) begin
            query_hit     = 1'b1;
            query_tag     = tail_reg;
            query_history = push_entry;
        end
`endif
    end

endmodule

// File: tb/tb_prediction_history_queue.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_prediction_history_queue;
    import prediction_history_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic                 clk;
    logic                 reset;
    logic                 is_stalling;
    logic                 push_valid;
    history_entry_t       push_entry;
    logic                 push_ready;
    logic [TAG_W-1:0]     push_tag;
    logic [INDEX_LEN-1:0] query_index;
    logic                 query_hit;
    history_entry_t       query_history;
    logic [TAG_W-1:0]     query_tag;
    logic                 retire_valid;
    history_entry_t       retire_history;
    logic                 flush_valid;
    logic [TAG_W-1:0]     flush_tag;
    logic                 full;
    logic                 empty;
    logic [TAG_W:0]       count;

    prediction_history_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .is_stalling    (is_stalling),
        .push_valid     (push_valid),
        .push_entry     (push_entry),
        .push_ready     (push_ready),
        .push_tag       (push_tag),
        .query_index    (query_index),
        .query_hit      (query_hit),
        .query_history  (query_history),
        .query_tag      (query_tag),
        .retire_valid   (retire_valid),
        .retire_history (retire_history),
        .flush_valid    (flush_valid),
        .flush_tag      (flush_tag),
        .full           (full),
        .empty          (empty),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int             slot;
        history_entry_t e;
    } item_t;

    item_t mq[$];
    int    m_tail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic history_entry_t mk(input int idx, input int tgt);
        history_entry_t e;
        e.index  = INDEX_LEN'(idx);
        e.taken  = tgt[0];
        e.target = TARGET_LEN'(tgt);
        return e;
    endfunction

    function automatic bit model_flush_ok();
        if (!flush_valid) return 1'b0;
        foreach (mq[i]) if (mq[i].slot == int'(flush_tag)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_push_ok();
        return reset && push_valid && (mq.size() < DEPTH) && !is_stalling && !model_flush_ok();
    endfunction

    task automatic compare_model();
        int             e_count, e_ptag, e_qtag;
        bit             e_hit;
        history_entry_t e_qh, e_rh;
        e_count = 0; e_ptag = 0; e_qtag = 0; e_hit = 1'b0; e_qh = '0; e_rh = '0;
        if (reset) begin
            e_count = mq.size();
            e_ptag  = m_tail;
            if (mq.size() > 0) e_rh = mq[0].e;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].e.index == query_index) begin
                    e_hit = 1'b1; e_qh = mq[i].e; e_qtag = mq[i].slot;
                    break;
                end
            end
`ifdef PRED_HIST_BYPASS_EN
            if (model_push_ok() && push_entry.index == query_index) begin
                e_hit = 1'b1; e_qh = push_entry; e_qtag = m_tail;
            end
`endif
        end
        chk("count",          64'(count),          64'(e_count));
        chk("full",           64'(full),           64'(e_count == DEPTH));
        chk("empty",          64'(empty),          64'(e_count == 0));
        chk("push_ready",     64'(push_ready),     64'(e_count != DEPTH));
        chk("push_tag",       64'(push_tag),       64'(e_ptag));
        chk("retire_history", 64'(retire_history), 64'(e_rh));
        chk("query_hit",      64'(query_hit),      64'(e_hit));
        chk("query_history",  64'(query_history),  64'(e_qh));
        chk("query_tag",      64'(query_tag),      64'(e_qtag));
    endtask

    task automatic update_model();
        bit f, p, r;
        int pos;
        if (!reset) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        f = model_flush_ok();
        p = model_push_ok();
        r = retire_valid && (mq.size() > 0);
        if (f) begin
            pos = 0;
            foreach (mq[i]) if (mq[i].slot == int'(flush_tag)) pos = i;
            while (mq.size() > pos + 1) void'(mq.pop_back());
            m_tail = (int'(flush_tag) + 1) % DEPTH;
        end
        if (r) void'(mq.pop_front());
        if (p) begin
            mq.push_back('{slot: m_tail, e: push_entry});
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic set_idle();
        push_valid   = 1'b0;
        push_entry   = '0;
        query_index  = '0;
        retire_valid = 1'b0;
        flush_valid  = 1'b0;
        flush_tag    = '0;
        is_stalling  = 1'b0;
    endtask

    task automatic drive(input bit pv, input history_entry_t pe, input int qi,
                         input bit rv, input bit fv, input int ft, input bit st);
        @(negedge clk);
        push_valid   = pv;
        push_entry   = pe;
        query_index  = INDEX_LEN'(qi);
        retire_valid = rv;
        flush_valid  = fv;
        flush_tag    = TAG_W'(ft);
        is_stalling  = st;
        #1;
        compare_model();
    endtask

    task automatic commit();
        @(posedge clk);
        update_model();
    endtask

    task automatic step(input bit pv, input history_entry_t pe, input int qi,
                        input bit rv, input bit fv, input int ft, input bit st);
        drive(pv, pe, qi, rv, fv, ft, st);
        commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        #1;
        compare_model();
        commit();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        set_idle();
        #2;
        chk("rst_count",      64'(count),          64'd0);
        chk("rst_empty",      64'(empty),          64'd1);
        chk("rst_full",       64'(full),           64'd0);
        chk("rst_push_ready", 64'(push_ready),     64'd1);
        chk("rst_push_tag",   64'(push_tag),       64'd0);
        chk("rst_query_hit",  64'(query_hit),      64'd0);
        chk("rst_retire",     64'(retire_history), 64'd0);
        do_reset();

        // Three pushes, then look up index 5.
        step(1, mk(3, 'h103), 0, 0, 0, 0, 0);
        step(1, mk(5, 'h105), 0, 0, 0, 0, 0);
        step(1, mk(7, 'h107), 0, 0, 0, 0, 0);
        drive(0, '0, 5, 0, 0, 0, 0);
        chk("a_count",    64'(count),     64'd3);
        chk("a_push_tag", 64'(push_tag),  64'd3);
        chk("a_hit",      64'(query_hit), 64'd1);
        chk("a_tag",      64'(query_tag), 64'd1);
        commit();

        // Fill, refused push while full, then two retires.
        step(1, mk(11, 'h10b), 0, 0, 0, 0, 0);
        drive(1, mk(13, 'h10d), 0, 0, 0, 0, 0);
        chk("b_full",       64'(full),       64'd1);
        chk("b_push_ready", 64'(push_ready), 64'd0);
        commit();
        drive(0, '0, 0, 1, 0, 0, 0);
        chk("b_ret0",  64'(retire_history.index), 64'd3);
        chk("b_count", 64'(count),                64'd4);
        commit();
        drive(0, '0, 0, 1, 0, 0, 0);
        chk("b_ret1", 64'(retire_history.index), 64'd5);
        commit();
        drive(0, '0, 0, 0, 0, 0, 0);
        chk("b_count2", 64'(count), 64'd2);
        commit();

        // Duplicate index: newest wins, including after tail wraps.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, mk(9, 100 + i), 0, 0, 0, 0, 0);
        drive(0, '0, 9, 0, 0, 0, 0);
        chk("c_tag",    64'(query_tag),            64'd3);
        chk("c_target", 64'(query_history.target), 64'd103);
        commit();
        step(0, '0, 0, 1, 0, 0, 0);
        step(1, mk(9, 200), 0, 0, 0, 0, 0);
        drive(0, '0, 9, 0, 0, 0, 0);
        chk("c_wrap_tag",    64'(query_tag),            64'd0);
        chk("c_wrap_target", 64'(query_history.target), 64'd200);
        commit();

        // Flush at slot 1 discards slots 2 and 3.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, mk(20 + i, 300 + i), 0, 0, 0, 0, 0);
        drive(0, '0, 22, 0, 1, 1, 0);
        chk("d_preflush_hit", 64'(query_hit), 64'd1);
        commit();
        drive(0, '0, 22, 0, 0, 0, 0);
        chk("d_count",    64'(count),     64'd2);
        chk("d_push_tag", 64'(push_tag),  64'd2);
        chk("d_miss22",   64'(query_hit), 64'd0);
        commit();
        drive(0, '0, 23, 0, 0, 0, 0);
        chk("d_miss23", 64'(query_hit), 64'd0);
        commit();

        // Flush at head together with retire and a dropped push.
        drive(1, mk(30, 400), 30, 1, 1, 0, 0);
        chk("e_no_bypass_on_flush", 64'(query_hit), 64'd0);
        commit();
        drive(0, '0, 30, 0, 0, 0, 0);
        chk("e_empty",    64'(empty),     64'd1);
        chk("e_count",    64'(count),     64'd0);
        chk("e_push_tag", 64'(push_tag),  64'd1);
        chk("e_miss",     64'(query_hit), 64'd0);
        commit();

        // Same-cycle lookup of the entry being pushed.
        drive(1, mk(40, 500), 40, 0, 0, 0, 0);
`ifdef PRED_HIST_BYPASS_EN
        chk("f_same_cycle", 64'(query_hit), 64'd1);
`else
        chk("f_same_cycle", 64'(query_hit), 64'd0);
`endif
        commit();
        drive(0, '0, 40, 0, 0, 0, 0);
        chk("f_next_cycle", 64'(query_hit), 64'd1);
        commit();

        // Asynchronous reset in the middle of a burst.
        do_reset();
        step(1, mk(50, 600), 0, 0, 0, 0, 0);
        drive(1, mk(51, 601), 50, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        chk("g_count",    64'(count),          64'd0);
        chk("g_empty",    64'(empty),          64'd1);
        chk("g_push_tag", 64'(push_tag),       64'd0);
        chk("g_hit",      64'(query_hit),      64'd0);
        chk("g_retire",   64'(retire_history), 64'd0);
        compare_model();
        set_idle();
        commit();
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) < 65,
                 mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535))),
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 8,
                 int'($urandom_range(0, DEPTH - 1)),
                 $urandom_range(0, 99) < 15);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
